// File: rtl/hpdl_pkg.sv
// Shared types and constants for the HPDL-1414 write scheduler.
// The optional cursor overlay is enabled with HPDL_CURSOR_BLINK_EN.
package hpdl_pkg;

    localparam int NUM_POS = 16;
    localparam logic [6:0] BLANK_CHAR  = 7'h20;
    localparam logic [6:0] CURSOR_CHAR = 7'h5F;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_e;

    // The glass only holds the 64-character upper-case set, so lower case
    // folds onto upper case and control codes become blanks.
    function automatic logic [6:0] fold_char(input logic [6:0] c);
        if (c >= 7'h60) begin
            return c - 7'h20;
        end else if (c < 7'h20) begin
            return BLANK_CHAR;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/hpdl_dirty_picker.sv
// Rotating-priority finder: first set bit of dirty_i at or after scan_ptr_i,
// wrapping modulo 16.
module hpdl_dirty_picker
    import hpdl_pkg::*;
(
    input  logic [NUM_POS-1:0] dirty_i,
    input  logic [3:0]         scan_ptr_i,
    output logic               found_o,
    output logic [3:0]         idx_o
);

    logic [3:0] cand;

    // Walk from the farthest offset down to zero so the nearest hit is the
    // last assignment and therefore wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = scan_ptr_i;
        cand    = scan_ptr_i;
        for (int i = NUM_POS - 1; i >= 0; i--) begin
            cand = scan_ptr_i + 4'(i);
            if (dirty_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/hpdl_write_scheduler.sv
// Shadow-buffered write scheduler for four cascaded HPDL-1414 displays.
// Define HPDL_CURSOR_BLINK_EN to build the blinking cursor overlay.
module hpdl_write_scheduler
    import hpdl_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 6,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned BLINK_DIV_W = 22
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       WR_VALID_i,
    output logic       WR_READY_o,
    input  logic [3:0] WR_POS_i,
    input  logic [6:0] WR_CHAR_i,
    input  logic       CLR_i,
    input  logic       CURSOR_EN_i,
    input  logic [3:0] CURSOR_POS_i,
    output logic [6:0] HPDL_D_o,
    output logic [1:0] HPDL_A_o,
    output logic [3:0] HPDL_WR_o,
    output logic       BUSY_o
);

    localparam int unsigned MAX_CYC =
        (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    state_e             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic [6:0]         shadow_q [NUM_POS];
    logic [NUM_POS-1:0] dirty_q, dirty_d, dirty_set, cursor_set;
    logic [3:0]         scan_ptr_q, scan_ptr_d;
    logic [1:0]         dev_q, dev_d;
    logic [6:0]         d_q, d_d;
    logic [1:0]         a_q, a_d;
    logic [3:0]         wr_q, wr_d;
    logic               accept, pick, found;
    logic [3:0]         pick_idx;
    logic [6:0]         pick_char;

    assign WR_READY_o = !CLR_i;
    assign accept     = WR_VALID_i && WR_READY_o;

    hpdl_dirty_picker u_picker (
        .dirty_i    (dirty_q),
        .scan_ptr_i (scan_ptr_q),
        .found_o    (found),
        .idx_o      (pick_idx)
    );

    // NOTE: the shadow buffer is reset like any other register because the
    // post-reset blank sequence reads it; it is small enough to be flops.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            for (int i = 0; i < NUM_POS; i++) shadow_q[i] <= BLANK_CHAR;
        end else if (CLR_i) begin
            for (int i = 0; i < NUM_POS; i++) shadow_q[i] <= BLANK_CHAR;
        end else if (accept) begin
            shadow_q[WR_POS_i] <= fold_char(WR_CHAR_i);
        end
    end

`ifdef HPDL_CURSOR_BLINK_EN
    logic [BLINK_DIV_W-1:0] blink_q;
    logic                   cur_en_q;
    logic [3:0]             cur_pos_q;
    logic                   blink_phase, blink_toggle, cursor_change;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            blink_q   <= '0;
            cur_en_q  <= 1'b0;
            cur_pos_q <= 4'd0;
        end else begin
            blink_q   <= blink_q + 1'b1;
            cur_en_q  <= CURSOR_EN_i;
            cur_pos_q <= CURSOR_POS_i;
        end
    end

    assign blink_phase   = blink_q[BLINK_DIV_W-1];
    // All low bits set means the MSB flips on this edge.
    assign blink_toggle  = &blink_q[BLINK_DIV_W-2:0];
    assign cursor_change = (cur_en_q != CURSOR_EN_i) || (cur_pos_q != CURSOR_POS_i);

    always_comb begin
        cursor_set = '0;
        if (CURSOR_EN_i && blink_toggle) cursor_set[CURSOR_POS_i] = 1'b1;
        if (cursor_change) begin
            cursor_set[cur_pos_q]    = 1'b1;
            cursor_set[CURSOR_POS_i] = 1'b1;
        end
    end

    assign pick_char = (CURSOR_EN_i && blink_phase && (pick_idx == CURSOR_POS_i))
                       ? CURSOR_CHAR : shadow_q[pick_idx];
`else
    logic unused_cursor;

    assign unused_cursor = ^{CURSOR_EN_i, CURSOR_POS_i, 32'(BLINK_DIV_W)};
    assign cursor_set    = '0;
    assign pick_char     = shadow_q[pick_idx];
`endif

    always_comb begin
        dirty_set = cursor_set;
        if (CLR_i) dirty_set = '1;
        else if (accept) dirty_set[WR_POS_i] = 1'b1;
    end

    // A set arriving in the pick cycle survives the clear, so the new data
    // gets its own write later.
    always_comb begin
        dirty_d = dirty_q;
        if (pick) dirty_d[pick_idx] = 1'b0;
        dirty_d = dirty_d | dirty_set;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dev_d      = dev_q;
        d_d        = d_q;
        a_d        = a_q;
        scan_ptr_d = scan_ptr_q;
        pick       = 1'b0;
        wr_d       = 4'hF;
        case (state_q)
            IDLE: begin
                if (found) begin
                    pick       = 1'b1;
                    state_d    = SETUP;
                    cnt_d      = cnt_t'(SETUP_CYC - 1);
                    dev_d      = pick_idx[3:2];
                    d_d        = pick_char;
                    a_d        = ~pick_idx[1:0];
                    scan_ptr_d = pick_idx + 4'd1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = cnt_t'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            STROBE: begin
                wr_d[dev_q] = 1'b0;
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = cnt_t'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dirty_q    <= '1;
            scan_ptr_q <= 4'd0;
            dev_q      <= 2'd0;
            d_q        <= BLANK_CHAR;
            a_q        <= 2'b11;
            wr_q       <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dirty_q    <= dirty_d;
            scan_ptr_q <= scan_ptr_d;
            dev_q      <= dev_d;
            d_q        <= d_d;
            a_q        <= a_d;
            wr_q       <= wr_d;
        end
    end

    assign HPDL_D_o  = d_q;
    assign HPDL_A_o  = a_q;
    assign HPDL_WR_o = wr_q;
    assign BUSY_o    = (dirty_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_hpdl_write_scheduler.sv
// Directed self-checking bench for hpdl_write_scheduler; a negedge monitor
// logs every strobe on the glass and the stimulus blocks compare the log.
module tb_hpdl_write_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_pos = 4'd0;
    logic [6:0] wr_char = 7'd0;
    logic       clr = 1'b0;
    logic       cursor_en = 1'b0;
    logic [3:0] cursor_pos = 4'd0;
    logic       wr_ready, busy;
    logic [6:0] hpdl_d;
    logic [1:0] hpdl_a;
    logic [3:0] hpdl_wr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int q_pos[$], q_data[$], q_a[$], q_wr[$], q_fall[$], q_width[$];
    logic [3:0] prev_wr = 4'hF;
    int low_cnt = 0;

    hpdl_write_scheduler #(.BLINK_DIV_W(4)) dut (
        .CLK_i        (clk),
        .RST_i        (rst),
        .WR_VALID_i   (wr_valid),
        .WR_READY_o   (wr_ready),
        .WR_POS_i     (wr_pos),
        .WR_CHAR_i    (wr_char),
        .CLR_i        (clr),
        .CURSOR_EN_i  (cursor_en),
        .CURSOR_POS_i (cursor_pos),
        .HPDL_D_o     (hpdl_d),
        .HPDL_A_o     (hpdl_a),
        .HPDL_WR_o    (hpdl_wr),
        .BUSY_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] dev_of(input logic [3:0] wr);
        logic [1:0] d = 2'd0;
        for (int i = 3; i >= 0; i--) if (!wr[i]) d = 2'(i);
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 4'hF;
            low_cnt = 0;
        end else begin
            if (prev_wr == 4'hF && hpdl_wr != 4'hF) begin
                q_pos.push_back(int'({dev_of(hpdl_wr), ~hpdl_a}));
                q_data.push_back(int'(hpdl_d));
                q_a.push_back(int'(hpdl_a));
                q_wr.push_back(int'(hpdl_wr));
                q_fall.push_back(cyc);
                low_cnt = 1;
                check("one_strobe_low", $countones(~hpdl_wr), 1);
            end else if (hpdl_wr != 4'hF) begin
                low_cnt++;
            end else if (prev_wr != 4'hF) begin
                q_width.push_back(low_cnt);
            end
            prev_wr = hpdl_wr;
        end
    end

    task automatic clear_log();
        q_pos.delete(); q_data.delete(); q_a.delete();
        q_wr.delete(); q_fall.delete(); q_width.delete();
    endtask

    task automatic post(input logic [3:0] p, input logic [6:0] c, output int acc);
        @(posedge clk); #2;
        wr_valid = 1'b1; wr_pos = p; wr_char = c;
        @(posedge clk); #1;
        acc = cyc;
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int idle_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        #1;
        idle_cyc = cyc;
        check(tag, busy, 0);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while (q_fall.size() < n && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, q_fall.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int acc, idle_cyc, n5f, nbuf;
        int exp_pos[4];
        int exp_dat[4];

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr", hpdl_wr, 4'hF);
        check("rst_d", hpdl_d, 7'h20);
        check("rst_a", hpdl_a, 2'b11);
        check("rst_busy", busy, 1);
        check("rst_ready", wr_ready, 1);
        clr = 1'b1; #1;
        check("ready_during_clr", wr_ready, 0);
        clr = 1'b0;

        // Post-reset blank: 16 writes of 0x20 in order, 11 cycles apart
        clear_log();
        @(posedge clk); #2 rst = 1'b0;
        wait_idle("blank_idle", idle_cyc);
        check("blank_count", q_fall.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < q_fall.size()) begin
                check($sformatf("blank_pos%0d", i), q_pos[i], i);
                check($sformatf("blank_data%0d", i), q_data[i], 7'h20);
                check($sformatf("blank_width%0d", i), q_width[i], 6);
                if (i > 0) check($sformatf("blank_gap%0d", i), q_fall[i] - q_fall[i-1], 11);
            end
        end
        if (q_fall.size() == 16) check("busy_fall_after_last", idle_cyc - q_fall[15], 7);

        // 'a' to pos 5: folded to 'A', device 1, digit address 2'b10
        clear_log();
        post(4'd5, 7'h61, acc);
        wait_idle("p5_idle", idle_cyc);
        check("p5_count", q_fall.size(), 1);
        if (q_fall.size() >= 1) begin
            check("p5_wr", q_wr[0], 4'b1101);
            check("p5_data", q_data[0], 7'h41);
            check("p5_addr", q_a[0], 2'b10);
            check("p5_latency", q_fall[0] - acc, 4);
            check("p5_width", q_width[0], 6);
        end

        // Rewrite pos 3 during its own strobe
        clear_log();
        post(4'd3, 7'h42, acc);
        wait_writes(1, "p3_first_fall");
        post(4'd3, 7'h43, acc);
        wait_idle("p3_idle", idle_cyc);
        check("p3_count", q_fall.size(), 2);
        if (q_fall.size() == 2) begin
            check("p3_first_data", q_data[0], 7'h42);
            check("p3_first_width", q_width[0], 6);
            check("p3_second_pos", q_pos[1], 3);
            check("p3_second_data", q_data[1], 7'h43);
        end

        // scan_ptr lands on 10 after pos 9; then 2, 9, 14 go dirty
        clear_log();
        post(4'd9, 7'h31, acc);
        wait_writes(1, "rr_first_fall");
        post(4'd2, 7'h05, acc);
        post(4'd9, 7'h59, acc);
        post(4'd14, 7'h7A, acc);
        wait_idle("rr_idle", idle_cyc);
        check("rr_count", q_fall.size(), 4);
        exp_pos = '{9, 14, 2, 9};
        exp_dat = '{7'h31, 7'h5A, 7'h20, 7'h59};
        for (int i = 0; i < 4; i++) begin
            if (i < q_fall.size()) begin
                check($sformatf("rr_pos%0d", i), q_pos[i], exp_pos[i]);
                check($sformatf("rr_data%0d", i), q_data[i], exp_dat[i]);
            end
        end

        // Clear with a concurrent write: write dropped, 16 blanks from pos 10
        clear_log();
        @(posedge clk); #2;
        clr = 1'b1; wr_valid = 1'b1; wr_pos = 4'd0; wr_char = 7'h51;
        #1 check("clr_ready", wr_ready, 0);
        @(posedge clk); #2;
        clr = 1'b0; wr_valid = 1'b0;
        wait_idle("clr_idle", idle_cyc);
        check("clr_count", q_fall.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < q_fall.size()) begin
                check($sformatf("clr_pos%0d", i), q_pos[i], (10 + i) % 16);
                check($sformatf("clr_data%0d", i), q_data[i], 7'h20);
            end
        end

        // Reset in the middle of a strobe
        clear_log();
        post(4'd0, 7'h4B, acc);
        wait_writes(1, "mid_first_fall");
        rst = 1'b1; #1;
        check("mid_rst_wr", hpdl_wr, 4'hF);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_d", hpdl_d, 7'h20);
        check("mid_rst_a", hpdl_a, 2'b11);
        @(posedge clk); #2;
        clear_log();
        rst = 1'b0;
        wait_idle("mid_idle", idle_cyc);
        check("mid_count", q_fall.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < q_fall.size()) check($sformatf("mid_data%0d", i), q_data[i], 7'h20);
        end

        // Cursor at pos 7
        clear_log();
        @(posedge clk); #2;
        cursor_pos = 4'd7; cursor_en = 1'b1;
`ifdef HPDL_CURSOR_BLINK_EN
        repeat (120) @(negedge clk);
        #1;
        n5f = 0; nbuf = 0;
        for (int i = 0; i < q_fall.size(); i++) begin
            if (q_pos[i] == 7 && q_data[i] == 7'h5F) n5f++;
            if (q_pos[i] == 7 && q_data[i] == 7'h20) nbuf++;
        end
        check("cursor_char_seen", n5f > 0, 1);
        check("cursor_buf_seen", nbuf > 0, 1);
        cursor_en = 1'b0;
        wait_idle("cursor_idle", idle_cyc);
`else
        n5f = 0; nbuf = 0;
        repeat (60) @(negedge clk);
        #1;
        check("cursor_ignored_writes", q_fall.size(), 0);
        check("cursor_ignored_busy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
